// File: rtl/packet_parse_pkg.sv
// Shared command encodings, field lengths and parser state type.
package packet_parse_pkg;

  localparam logic [8:0] CMD_ACK      = 9'b0_0000_0010;
  localparam logic [8:0] CMD_QUERY    = 9'b0_0000_0100;
  localparam logic [8:0] CMD_QUERYADJ = 9'b0_0000_1000;
  localparam logic [8:0] CMD_KILL     = 9'b0_0001_0000;
  localparam logic [8:0] CMD_REQRN    = 9'b0_0100_0000;
  localparam logic [8:0] CMD_READ     = 9'b0_1000_0000;
  localparam logic [8:0] CMD_WRITE    = 9'b1_0000_0000;
  localparam logic [8:0] CMD_MASK     = CMD_ACK | CMD_QUERY | CMD_QUERYADJ | CMD_KILL |
                                        CMD_REQRN | CMD_READ | CMD_WRITE;

  localparam int QUERY_SKIP_LEN    = 9;
  localparam int QUERYADJ_SKIP_LEN = 2;
  localparam int RFU_LEN           = 3;
  localparam int EBV_GROUP_LEN     = 8;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_SKIP   = 4'd1,
    ST_QFIELD = 4'd2,
    ST_BANK   = 4'd3,
    ST_EBV    = 4'd4,
    ST_WORDS  = 4'd5,
    ST_DATA   = 4'd6,
    ST_RFU    = 4'd7,
    ST_HANDLE = 4'd8,
    ST_DONE   = 4'd9
  } state_e;

  // Exactly one bit set, and that bit is a defined command.
  function automatic logic cmd_valid(input logic [8:0] ptype);
    return $onehot(ptype) && ((ptype & CMD_MASK) != 9'd0);
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/handle_cmp.sv
// Bit-serial handle comparator, MSB first, one bit per edge while active.
module handle_cmp #(
  parameter int HANDLE_W = 16,
  parameter int IDX_W    = 5
) (
  input  logic                bitinclk,
  input  logic                clr,
  input  logic                active,
  input  logic [IDX_W-1:0]    idx,
  input  logic                bitin,
  input  logic [HANDLE_W-1:0] handle,
  output logic                match,
  output logic                fail,
  output logic                miss,
  output logic                early
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HANDLE_W - 1);

  logic [HANDLE_W-1:0] handle_sh;
  logic                bit_ok;
  logic                last_ok;

  // Shift rather than index so the expected bit is always the MSB.
  assign handle_sh = handle << idx;
  assign bit_ok    = (bitin == handle_sh[HANDLE_W-1]);
  assign miss      = active & ~bit_ok;
  assign last_ok   = active & bit_ok & (idx == LAST_IDX) & ~fail;
  assign early     = match | last_ok;

  // Sticky match/fail flags, cleared at the start of every packet.
  always_ff @(posedge bitinclk) begin
    if (clr) begin
      match <= 1'b0;
      fail  <= 1'b0;
    end else begin
      if (miss)    fail  <= 1'b1;
      if (last_ok) match <= 1'b1;
    end
  end

endmodule

// File: rtl/packet_parse_ebv.sv
// Serial command field parser: one bit per bitinclk edge, routed by a latched one-hot command.
//
//  state     | meaning
//  ST_IDLE   | wait for valid command; its first bit is consumed on the latching edge
//  ST_SKIP   | discard QUERY/QUERYADJ leading bits
//  ST_QFIELD | shift Q (QUERY) or UpDn (QUERYADJ)
//  ST_BANK   | 2-bit memory bank
//  ST_EBV    | 8-bit groups: extension flag then 7 pointer bits
//  ST_WORDS  | READ word count
//  ST_DATA   | WRITE data / KILL password half, de-covered with currentrn
//  ST_RFU    | KILL reserved bits, ignored
//  ST_HANDLE | serial handle compare
//  ST_DONE   | packet finished, bits ignored, outputs held
module packet_parse_ebv
  import packet_parse_pkg::*;
#(
  parameter int HANDLE_W  = 16,
  parameter int PTR_W     = 16,
  parameter int WORDCNT_W = 8,
  parameter int DATA_W    = 16
) (
  input  logic                 bitinclk,
  input  logic                 reset,
  input  logic                 pkt_start,
  input  logic                 bitin,
  input  logic [8:0]           packettype,
  input  logic [HANDLE_W-1:0]  currenthandle,
  input  logic [DATA_W-1:0]    currentrn,
  output logic [3:0]           rx_q,
  output logic [2:0]           rx_updn,
  output logic [1:0]           readwritebank,
  output logic [PTR_W-1:0]     readwriteptr,
  output logic [WORDCNT_W-1:0] readwords,
  output logic                 writedataout,
  output logic                 writedataen,
  output logic                 handlematch,
  output logic                 handlematch_early,
  output logic                 ptr_overflow,
  output logic                 matchfailed,
  output logic                 parse_done
);

  localparam int MAX_FIELD = max_of(max_of(HANDLE_W, DATA_W), max_of(WORDCNT_W, QUERY_SKIP_LEN));
  localparam int CNT_W     = $clog2(MAX_FIELD) + 1;

  localparam logic [CNT_W-1:0] LAST_QSKIP  = CNT_W'(QUERY_SKIP_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_QASKIP = CNT_W'(QUERYADJ_SKIP_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_Q      = CNT_W'(3);
  localparam logic [CNT_W-1:0] LAST_UPDN   = CNT_W'(2);
  localparam logic [CNT_W-1:0] LAST_BANK   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_EBV    = CNT_W'(EBV_GROUP_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_WORDS  = CNT_W'(WORDCNT_W - 1);
  localparam logic [CNT_W-1:0] LAST_DATA   = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LAST_RFU    = CNT_W'(RFU_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_HANDLE = CNT_W'(HANDLE_W - 1);

  state_e           state, state_nx, st_eff;
  logic [CNT_W-1:0] cnt, cnt_nx, cnt_eff, last_idx;
  logic [8:0]       ptype, ptype_eff;
  logic             is_query;
  logic             ebv_ext;
  logic             field_end;
  logic             consume;
  logic             hs_miss;
  logic [DATA_W-1:0] rn_sh;

  function automatic state_e first_state(input logic [8:0] p);
    state_e s;
    s = ST_IDLE;
    if (p == CMD_QUERY || p == CMD_QUERYADJ)  s = ST_SKIP;
    else if (p == CMD_ACK || p == CMD_REQRN)  s = ST_HANDLE;
    else if (p == CMD_READ || p == CMD_WRITE) s = ST_BANK;
    else if (p == CMD_KILL)                   s = ST_DATA;
    return s;
  endfunction

  // In IDLE the current bit is treated as bit 0 of the new command's first field.
  always_comb begin
    st_eff    = state;
    ptype_eff = ptype;
    cnt_eff   = cnt;
    if (state == ST_IDLE) begin
      ptype_eff = packettype;
      cnt_eff   = '0;
      st_eff    = cmd_valid(packettype) ? first_state(packettype) : ST_IDLE;
    end
  end

  assign is_query = (ptype_eff == CMD_QUERY);
  assign consume  = (st_eff != ST_IDLE) && (st_eff != ST_DONE);

  // Last bit index of the field being received.
  always_comb begin
    last_idx = '0;
    case (st_eff)
      ST_SKIP:   last_idx = is_query ? LAST_QSKIP : LAST_QASKIP;
      ST_QFIELD: last_idx = is_query ? LAST_Q : LAST_UPDN;
      ST_BANK:   last_idx = LAST_BANK;
      ST_EBV:    last_idx = LAST_EBV;
      ST_WORDS:  last_idx = LAST_WORDS;
      ST_DATA:   last_idx = LAST_DATA;
      ST_RFU:    last_idx = LAST_RFU;
      ST_HANDLE: last_idx = LAST_HANDLE;
      default:   last_idx = '0;
    endcase
  end

  assign field_end = (cnt_eff == last_idx);

  // Field sequencing; a handle mismatch ends the packet immediately.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (consume) begin
      state_nx = st_eff;
      cnt_nx   = field_end ? '0 : cnt_eff + CNT_W'(1);
      if (st_eff == ST_HANDLE && hs_miss) begin
        state_nx = ST_DONE;
        cnt_nx   = '0;
      end else if (field_end) begin
        case (st_eff)
          ST_SKIP:   state_nx = ST_QFIELD;
          ST_QFIELD: state_nx = ST_DONE;
          ST_BANK:   state_nx = ST_EBV;
          ST_EBV:    if (!ebv_ext) state_nx = (ptype_eff == CMD_READ) ? ST_WORDS : ST_DATA;
          ST_WORDS:  state_nx = ST_HANDLE;
          ST_DATA:   state_nx = (ptype_eff == CMD_KILL) ? ST_RFU : ST_HANDLE;
          ST_RFU:    state_nx = ST_HANDLE;
          ST_HANDLE: state_nx = ST_DONE;
          default:   state_nx = st_eff;
        endcase
      end
    end
  end

  assign rn_sh = currentrn << cnt_eff;

  // State, counter and field registers; pkt_start clears exactly like reset.
  always_ff @(posedge bitinclk) begin
    if (reset || pkt_start) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      ptype         <= '0;
      ebv_ext       <= 1'b0;
      rx_q          <= '0;
      rx_updn       <= '0;
      readwritebank <= '0;
      readwriteptr  <= '0;
      readwords     <= '0;
      ptr_overflow  <= 1'b0;
      writedataout  <= 1'b0;
      writedataen   <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      ptype       <= ptype_eff;
      writedataen <= (st_eff == ST_DATA);
      case (st_eff)
        ST_QFIELD: begin
          if (is_query) rx_q    <= {rx_q[2:0], bitin};
          else          rx_updn <= {rx_updn[1:0], bitin};
        end
        ST_BANK:  readwritebank <= {readwritebank[0], bitin};
        ST_EBV: begin
          if (cnt_eff == '0) begin
            ebv_ext <= bitin;
          end else begin
            readwriteptr <= (readwriteptr << 1) | PTR_W'(bitin);
            if (readwriteptr[PTR_W-1]) ptr_overflow <= 1'b1;
          end
        end
        ST_WORDS: readwords    <= (readwords << 1) | WORDCNT_W'(bitin);
        ST_DATA:  writedataout <= bitin ^ rn_sh[DATA_W-1];
        default: ;
      endcase
    end
  end

  assign parse_done = (state == ST_DONE);

  handle_cmp #(
    .HANDLE_W (HANDLE_W),
    .IDX_W    (CNT_W)
  ) u_handle_cmp (
    .bitinclk (bitinclk),
    .clr      (reset | pkt_start),
    .active   (st_eff == ST_HANDLE),
    .idx      (cnt_eff),
    .bitin    (bitin),
    .handle   (currenthandle),
    .match    (handlematch),
    .fail     (matchfailed),
    .miss     (hs_miss),
    .early    (handlematch_early)
  );

endmodule

// File: tb/tb_packet_parse_ebv.sv
// Directed and randomized packets checked against a field-level model of the command formats.
module tb_packet_parse_ebv;

  localparam int HW = 16;
  localparam int PW = 16;
  localparam int WW = 8;
  localparam int DW = 16;

  localparam logic [8:0] T_ACK   = 9'h002;
  localparam logic [8:0] T_QUERY = 9'h004;
  localparam logic [8:0] T_QADJ  = 9'h008;
  localparam logic [8:0] T_KILL  = 9'h010;
  localparam logic [8:0] T_REQRN = 9'h040;
  localparam logic [8:0] T_READ  = 9'h080;
  localparam logic [8:0] T_WRITE = 9'h100;

  logic          bitinclk = 1'b0;
  logic          reset, pkt_start, bitin;
  logic [8:0]    packettype;
  logic [HW-1:0] currenthandle;
  logic [DW-1:0] currentrn;

  logic [3:0]    rx_q;
  logic [2:0]    rx_updn;
  logic [1:0]    readwritebank;
  logic [PW-1:0] readwriteptr;
  logic [WW-1:0] readwords;
  logic          writedataout, writedataen, handlematch, handlematch_early;
  logic          ptr_overflow, matchfailed, parse_done;

  logic [3:0]    rx_q_n;
  logic [2:0]    rx_updn_n;
  logic [1:0]    readwritebank_n;
  logic [7:0]    readwriteptr_n;
  logic [WW-1:0] readwords_n;
  logic          writedataout_n, writedataen_n, handlematch_n, handlematch_early_n;
  logic          ptr_overflow_n, matchfailed_n, parse_done_n;

  packet_parse_ebv #(.HANDLE_W(HW), .PTR_W(PW), .WORDCNT_W(WW), .DATA_W(DW)) dut (
    .bitinclk(bitinclk), .reset(reset), .pkt_start(pkt_start), .bitin(bitin),
    .packettype(packettype), .currenthandle(currenthandle), .currentrn(currentrn),
    .rx_q(rx_q), .rx_updn(rx_updn), .readwritebank(readwritebank),
    .readwriteptr(readwriteptr), .readwords(readwords), .writedataout(writedataout),
    .writedataen(writedataen), .handlematch(handlematch),
    .handlematch_early(handlematch_early), .ptr_overflow(ptr_overflow),
    .matchfailed(matchfailed), .parse_done(parse_done));

  packet_parse_ebv #(.HANDLE_W(HW), .PTR_W(8), .WORDCNT_W(WW), .DATA_W(DW)) dut_n (
    .bitinclk(bitinclk), .reset(reset), .pkt_start(pkt_start), .bitin(bitin),
    .packettype(packettype), .currenthandle(currenthandle), .currentrn(currentrn),
    .rx_q(rx_q_n), .rx_updn(rx_updn_n), .readwritebank(readwritebank_n),
    .readwriteptr(readwriteptr_n), .readwords(readwords_n), .writedataout(writedataout_n),
    .writedataen(writedataen_n), .handlematch(handlematch_n),
    .handlematch_early(handlematch_early_n), .ptr_overflow(ptr_overflow_n),
    .matchfailed(matchfailed_n), .parse_done(parse_done_n));

  always #5 bitinclk = ~bitinclk;

  int checks = 0;
  int errors = 0;

  bit bits_q[$];
  bit early_q[$], hm_q[$], done_q[$], den_q[$], dout_q[$];

  logic [3:0]    e_q;
  logic [2:0]    e_updn;
  logic [1:0]    e_bank;
  logic [63:0]   e_val;
  logic [WW-1:0] e_words;
  logic [DW-1:0] e_data;
  bit            e_has_data, e_match, e_fail;
  int            e_len, e_hpos;

  logic [8:0] bad_types [4] = '{9'h000, 9'h001, 9'h020, 9'h006};
  logic [8:0] cmd_types [7] = '{T_ACK, T_QUERY, T_QADJ, T_KILL, T_REQRN, T_READ, T_WRITE};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    bits_q.delete();
    e_q = '0; e_updn = '0; e_bank = '0; e_val = '0; e_words = '0; e_data = '0;
    e_has_data = 0; e_match = 0; e_fail = 0; e_len = 0; e_hpos = -1;
  endtask

  task automatic push_val(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) bits_q.push_back(v[i]);
  endtask

  // Minimal 7-bit groups for v, optionally padded with leading all-zero groups.
  task automatic push_ebv(input logic [63:0] v, input int extra);
    int n;
    n = 1;
    while ((v >> (7 * n)) != 64'd0) n++;
    n += extra;
    e_val = v;
    for (int g = n - 1; g >= 0; g--) begin
      bits_q.push_back(g != 0);
      push_val((v >> (7 * g)) & 64'h7F, 7);
    end
  endtask

  task automatic push_data(input logic [DW-1:0] d);
    push_val(64'(d), DW);
    e_data = d ^ currentrn;
    e_has_data = 1;
  endtask

  // miss_at < 0: send the correct handle; else flip the bit sent at position miss_at.
  task automatic push_handle(input int miss_at);
    logic [HW-1:0] h;
    h = currenthandle;
    if (miss_at < 0) begin
      e_match = 1;
      e_len   = bits_q.size() + HW;
      e_hpos  = e_len - 1;
    end else begin
      h[HW-1-miss_at] = ~h[HW-1-miss_at];
      e_fail = 1;
      e_len  = bits_q.size() + miss_at + 1;
    end
    push_val(64'(h), HW);
  endtask

  task automatic build_random(input logic [8:0] t);
    int miss;
    logic [63:0] v;
    model_clear();
    miss = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, HW - 1)) : -1;
    v = {$urandom, $urandom} >> $urandom_range(40, 63);
    case (t)
      T_QUERY: begin
        push_val(64'($urandom), 9); e_q = 4'($urandom); push_val(64'(e_q), 4); e_len = 13;
      end
      T_QADJ: begin
        push_val(64'($urandom), 2); e_updn = 3'($urandom); push_val(64'(e_updn), 3); e_len = 5;
      end
      T_ACK, T_REQRN: push_handle(miss);
      T_READ: begin
        e_bank = 2'($urandom); push_val(64'(e_bank), 2);
        push_ebv(v, int'($urandom_range(0, 1)));
        e_words = WW'($urandom); push_val(64'(e_words), WW);
        push_handle(miss);
      end
      T_WRITE: begin
        e_bank = 2'($urandom); push_val(64'(e_bank), 2);
        push_ebv(v, int'($urandom_range(0, 1)));
        push_data(DW'($urandom));
        push_handle(miss);
      end
      T_KILL: begin
        push_data(DW'($urandom));
        push_val(64'($urandom), 3);
        push_handle(miss);
      end
      default: ;
    endcase
  endtask

  // pkt_start pulse (its bit is discarded), then a few edges with invalid types.
  task automatic start_pkt(input logic [8:0] t);
    int n_idle;
    pkt_start = 1'b1; packettype = t; bitin = 1'($urandom);
    @(posedge bitinclk); #1;
    pkt_start = 1'b0;
    n_idle = int'($urandom_range(0, 2));
    for (int i = 0; i < n_idle; i++) begin
      packettype = bad_types[$urandom_range(0, 3)];
      bitin = 1'($urandom);
      @(posedge bitinclk); #1;
    end
    if (n_idle > 0)
      chk("idle_hold", 64'({parse_done, handlematch, matchfailed, rx_q, readwritebank, readwriteptr, writedataen}), 64'd0);
    packettype = t;
  endtask

  task automatic send_bits(input int n);
    early_q.delete(); hm_q.delete(); done_q.delete(); den_q.delete(); dout_q.delete();
    for (int i = 0; i < n; i++) begin
      bitin = bits_q[i];
      #1;
      early_q.push_back(handlematch_early);
      @(posedge bitinclk); #1;
      hm_q.push_back(handlematch);
      done_q.push_back(parse_done);
      den_q.push_back(writedataen);
      dout_q.push_back(writedataout);
      if (i == 0) packettype = 9'($urandom);
    end
  endtask

  task automatic check_pkt(input string nm);
    int cnt, first, last;
    logic [DW-1:0] got;
    for (int i = 0; i < 2; i++) begin
      bitin = 1'($urandom);
      @(posedge bitinclk); #1;
    end
    chk({nm, ".rx_q"}, 64'(rx_q), 64'(e_q));
    chk({nm, ".rx_updn"}, 64'(rx_updn), 64'(e_updn));
    chk({nm, ".bank"}, 64'(readwritebank), 64'(e_bank));
    chk({nm, ".ptr"}, 64'(readwriteptr), e_val & 64'hFFFF);
    chk({nm, ".ovf"}, 64'(ptr_overflow), 64'((e_val >> 16) != 0));
    chk({nm, ".words"}, 64'(readwords), 64'(e_words));
    chk({nm, ".match"}, 64'(handlematch), 64'(e_match));
    chk({nm, ".early_hold"}, 64'(handlematch_early), 64'(e_match));
    chk({nm, ".failed"}, 64'(matchfailed), 64'(e_fail));
    chk({nm, ".done"}, 64'(parse_done), 64'd1);
    chk({nm, ".wd_last"}, 64'({writedataen, writedataout}), 64'(e_has_data ? e_data[0] : 1'b0));
    chk({nm, ".n_ptr"}, 64'(readwriteptr_n), e_val & 64'hFF);
    chk({nm, ".n_ovf"}, 64'(ptr_overflow_n), 64'((e_val >> 8) != 0));
    chk({nm, ".n_fields"},
        64'({rx_q_n, rx_updn_n, readwritebank_n, readwords_n, handlematch_n, handlematch_early_n,
             matchfailed_n, parse_done_n, writedataen_n, writedataout_n}),
        64'({e_q, e_updn, e_bank, e_words, e_match, e_match, e_fail, 1'b1, 1'b0,
             (e_has_data ? e_data[0] : 1'b0)}));
    chk({nm, ".done_edge"}, 64'(done_q[e_len-1]), 64'd1);
    if (e_len > 1) chk({nm, ".done_before"}, 64'(done_q[e_len-2]), 64'd0);
    if (e_hpos > 0) begin
      chk({nm, ".early_last"}, 64'(early_q[e_hpos]), 64'd1);
      chk({nm, ".early_prev"}, 64'(early_q[e_hpos-1]), 64'd0);
      chk({nm, ".hm_edge"}, 64'(hm_q[e_hpos]), 64'd1);
      chk({nm, ".hm_before"}, 64'(hm_q[e_hpos-1]), 64'd0);
    end
    cnt = 0; first = -1; last = -1; got = '0;
    for (int i = 0; i < den_q.size(); i++) begin
      if (den_q[i]) begin
        cnt++;
        if (first < 0) first = i;
        last = i;
        got = {got[DW-2:0], dout_q[i]};
      end
    end
    chk({nm, ".wde_cycles"}, 64'(cnt), 64'(e_has_data ? DW : 0));
    if (e_has_data) begin
      chk({nm, ".wd_stream"}, 64'(got), 64'(e_data));
      chk({nm, ".wde_contig"}, 64'(last - first + 1), 64'(DW));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] t;
    reset = 1'b1; pkt_start = 1'b0; bitin = 1'b0; packettype = '0;
    currenthandle = '0; currentrn = '0;
    repeat (2) @(posedge bitinclk);
    #1;
    chk("rst.outs", 64'({rx_q, rx_updn, readwritebank, readwriteptr, readwords, writedataout, writedataen,
                        handlematch, handlematch_early, ptr_overflow, matchfailed, parse_done}), 64'd0);
    chk("rst.outs_n", 64'({rx_q_n, rx_updn_n, readwritebank_n, readwriteptr_n, readwords_n, writedataout_n,
                          writedataen_n, handlematch_n, handlematch_early_n, ptr_overflow_n,
                          matchfailed_n, parse_done_n}), 64'd0);
    reset = 1'b0;

    // QUERY: 9 skip bits then 1010
    model_clear();
    push_val(64'h1A5, 9); push_val(64'hA, 4); e_q = 4'hA; e_len = 13;
    start_pkt(T_QUERY); send_bits(bits_q.size()); check_pkt("query");

    // READ bank 01, pointer 0x85 in two groups, 2 words, matching handle 0xBEEF
    currenthandle = 16'hBEEF;
    model_clear();
    e_bank = 2'b01; push_val(64'd1, 2);
    push_ebv(64'h85, 0);
    e_words = 8'h02; push_val(64'h02, WW);
    push_handle(-1);
    start_pkt(T_READ); send_bits(bits_q.size()); check_pkt("read");

    // WRITE rn 0x1234 data 0x5555, handle bit 3 flipped
    currentrn = 16'h1234; currenthandle = 16'hC3A5;
    model_clear();
    e_bank = 2'b10; push_val(64'd2, 2);
    push_ebv(64'h3, 0);
    push_data(16'h5555);
    push_handle(3);
    start_pkt(T_WRITE); send_bits(bits_q.size()); check_pkt("write");
    chk("write.stream_const", 64'(e_data), 64'h4761);

    // Pointer 0x1FF: narrow instance keeps 0xFF and flags overflow
    model_clear();
    e_bank = 2'b11; push_val(64'd3, 2);
    push_ebv(64'h1FF, 0);
    e_words = 8'h5A; push_val(64'h5A, WW);
    push_handle(-1);
    start_pkt(T_READ); send_bits(bits_q.size()); check_pkt("ovf8");

    // ACK with matching handle
    currenthandle = 16'h1357;
    model_clear(); push_handle(-1);
    start_pkt(T_ACK); send_bits(bits_q.size()); check_pkt("ack");

    // Abort READ mid-EBV, then QUERYADJ 2 skip + 110
    model_clear();
    e_bank = 2'b11; push_val(64'd3, 2);
    push_ebv(64'h3FFF, 0);
    start_pkt(T_READ); send_bits(6);
    chk("abort.partial_bank", 64'(readwritebank), 64'd3);
    model_clear();
    push_val(64'd2, 2); e_updn = 3'b110; push_val(64'h6, 3); e_len = 5;
    start_pkt(T_QADJ); send_bits(bits_q.size()); check_pkt("qadj_abort");

    // reset together with pkt_start in the middle of a WRITE
    build_random(T_WRITE);
    start_pkt(T_WRITE); send_bits(20);
    reset = 1'b1; pkt_start = 1'b1;
    @(posedge bitinclk); #1;
    chk("rst_mid.outs", 64'({rx_q, rx_updn, readwritebank, readwriteptr, readwords, writedataout, writedataen,
                            handlematch, handlematch_early, ptr_overflow, matchfailed, parse_done}), 64'd0);
    reset = 1'b0; pkt_start = 1'b0;

    // Randomized packets of every command type
    for (int n = 0; n < 40; n++) begin
      t = cmd_types[$urandom_range(0, 6)];
      currenthandle = HW'($urandom);
      currentrn     = DW'($urandom);
      build_random(t);
      start_pkt(t);
      send_bits(bits_q.size());
      check_pkt($sformatf("rand%0d_%03h", n, t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
